// File: rtl/rr_pipe_pkg.sv
// Shared limits and helper functions for the register-read pipeline.
package rr_pipe_pkg;

  localparam int RR_DEPTH_MIN = 1;
  localparam int RR_DEPTH_MAX = 4;
  localparam int NUM_SRC_MIN  = 1;
  localparam int NUM_SRC_MAX  = 3;

  function automatic bit rrParamsOk(input int depth, input int numSrc);
    return (depth >= RR_DEPTH_MIN) && (depth <= RR_DEPTH_MAX) &&
           (numSrc >= NUM_SRC_MIN) && (numSrc <= NUM_SRC_MAX);
  endfunction

  // Tags are zero-extended to 32 bits so one helper serves every tag width.
  function automatic logic busHit(input logic busValid, input logic [31:0] busTag,
                                  input logic [31:0] tag);
    return busValid && (busTag == tag);
  endfunction

endpackage

// File: rtl/rr_operand_capture.sv
// One source-operand slot of one stage: bypass snoop, lowest-bus priority and the cap/data register.
module rr_operand_capture
  import rr_pipe_pkg::*;
#(
  parameter int ISSUE_WIDTH = 4,
  parameter int DATA_W      = 64,
  parameter int PHYS_LOG    = 7,
  parameter bit REGISTERED  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          advance,
  input  logic                          stageValid,
  input  logic [PHYS_LOG-1:0]           tag,
  input  logic                          upCap,
  input  logic [DATA_W-1:0]             upData,
  input  logic [ISSUE_WIDTH-1:0]        bypassValid,
  input  logic [ISSUE_WIDTH*PHYS_LOG-1:0] bypassTag,
  input  logic [ISSUE_WIDTH*DATA_W-1:0] bypassData,
  output logic                          capNext,
  output logic [DATA_W-1:0]             dataNext
);

  logic              cap_reg;
  logic [DATA_W-1:0] capData_reg;
  logic              capNow;
  logic [DATA_W-1:0] capDataNow;
  logic              hit;
  logic [DATA_W-1:0] hitData;

  // Scan from the top bus down so the lowest-numbered match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    for (int j = ISSUE_WIDTH - 1; j >= 0; j--) begin
      if (busHit(bypassValid[j], 32'(bypassTag[j*PHYS_LOG +: PHYS_LOG]), 32'(tag))) begin
        hit     = 1'b1;
        hitData = bypassData[j*DATA_W +: DATA_W];
      end
    end
  end

  assign capNow     = REGISTERED ? cap_reg     : 1'b0;
  assign capDataNow = REGISTERED ? capData_reg : '0;
  assign capNext    = capNow | (stageValid & hit);
  assign dataNext   = capNow ? capDataNow : hitData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_reg     <= 1'b0;
      capData_reg <= '0;
    end else if (clear) begin
      cap_reg     <= 1'b0;
    end else if (advance) begin
      cap_reg     <= upCap;
      capData_reg <= upData;
    end else begin
      cap_reg     <= capNext;
      capData_reg <= dataNext;
    end
  end

endmodule

// File: rtl/reg_read_pipe.sv
// Register-read stage: carries payload and source tags through RR_DEPTH stages,
// snooping bypass buses everywhere, with valid/ready backpressure and recovery flush.
module reg_read_pipe
  import rr_pipe_pkg::*;
#(
  parameter int RR_DEPTH    = 3,
  parameter int NUM_SRC     = 2,
  parameter int ISSUE_WIDTH = 4,
  parameter int DATA_W      = 64,
  parameter int PHYS_LOG    = 7,
  parameter int PAYLOAD_W   = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            recover_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [PAYLOAD_W-1:0]            payload_i,
  input  logic [NUM_SRC*PHYS_LOG-1:0]     phySrc_i,
  input  logic [ISSUE_WIDTH-1:0]          bypassValid_i,
  input  logic [ISSUE_WIDTH*PHYS_LOG-1:0] bypassTag_i,
  input  logic [ISSUE_WIDTH*DATA_W-1:0]   bypassData_i,
  output logic [NUM_SRC*PHYS_LOG-1:0]     rfAddr_o,
  input  logic [NUM_SRC*DATA_W-1:0]       rfData_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [PAYLOAD_W-1:0]            payload_o,
  output logic [NUM_SRC*PHYS_LOG-1:0]     phySrc_o,
  output logic [NUM_SRC*DATA_W-1:0]       srcData_o
);

  typedef struct packed {
    logic                        valid;
    logic [PAYLOAD_W-1:0]        payload;
    logic [NUM_SRC*PHYS_LOG-1:0] tags;
  } rrStage_t;

  logic validOut;
  logic stall;
  logic advance;

  if (!rrParamsOk(RR_DEPTH, NUM_SRC)) begin : gBadParams
    $error("reg_read_pipe: RR_DEPTH must be 1..4 and NUM_SRC 1..3");
  end

  // Recover masks the output so it can never register as a stall.
  assign stall   = validOut & ~ready_i;
  assign advance = ~stall;
  assign ready_o = ~stall;
  assign valid_o = validOut;

  if (RR_DEPTH == 1) begin : gComb
    logic [NUM_SRC-1:0] haveData;
    logic [DATA_W-1:0]  resData [NUM_SRC];

    assign validOut  = valid_i & ~recover_i;
    assign payload_o = payload_i;
    assign phySrc_o  = phySrc_i;
    assign rfAddr_o  = phySrc_i;

    for (genvar gk = 0; gk < NUM_SRC; gk++) begin : gSrc
      rr_operand_capture #(
        .ISSUE_WIDTH(ISSUE_WIDTH), .DATA_W(DATA_W), .PHYS_LOG(PHYS_LOG), .REGISTERED(1'b0)
      ) uCap (
        .clk(clk), .reset(reset), .clear(recover_i), .advance(1'b1),
        .stageValid(valid_i), .tag(phySrc_i[gk*PHYS_LOG +: PHYS_LOG]),
        .upCap(1'b0), .upData('0),
        .bypassValid(bypassValid_i), .bypassTag(bypassTag_i), .bypassData(bypassData_i),
        .capNext(haveData[gk]), .dataNext(resData[gk])
      );
      assign srcData_o[gk*DATA_W +: DATA_W] =
        validOut ? (haveData[gk] ? resData[gk] : rfData_i[gk*DATA_W +: DATA_W]) : '0;
    end
  end else begin : gPipe
    localparam int NS   = RR_DEPTH - 1;
    localparam int LAST = NS - 1;

    for (genvar gi = 0; gi < NS; gi++) begin : gStage
      rrStage_t           stage_reg;
      rrStage_t           upStage;
      logic [NUM_SRC-1:0] upCap;
      logic [NUM_SRC-1:0] capNext;
      logic [DATA_W-1:0]  upData   [NUM_SRC];
      logic [DATA_W-1:0]  dataNext [NUM_SRC];

      if (gi == 0) begin : gHead
        assign upStage = {valid_i & ready_o, payload_i, phySrc_i};
        assign upCap   = '0;
        assign upData  = '{default: '0};
      end else begin : gBody
        assign upStage = gStage[gi-1].stage_reg;
        assign upCap   = gStage[gi-1].capNext;
        assign upData  = gStage[gi-1].dataNext;
      end

      // A stall freezes the whole pipe; only the capture slots keep updating.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_reg <= '0;
        end else if (recover_i) begin
          stage_reg.valid <= 1'b0;
        end else if (advance) begin
          stage_reg <= upStage;
        end
      end

      for (genvar gk = 0; gk < NUM_SRC; gk++) begin : gSrc
        rr_operand_capture #(
          .ISSUE_WIDTH(ISSUE_WIDTH), .DATA_W(DATA_W), .PHYS_LOG(PHYS_LOG), .REGISTERED(1'b1)
        ) uCap (
          .clk(clk), .reset(reset), .clear(recover_i), .advance(advance),
          .stageValid(stage_reg.valid), .tag(stage_reg.tags[gk*PHYS_LOG +: PHYS_LOG]),
          .upCap(upCap[gk]), .upData(upData[gk]),
          .bypassValid(bypassValid_i), .bypassTag(bypassTag_i), .bypassData(bypassData_i),
          .capNext(capNext[gk]), .dataNext(dataNext[gk])
        );
      end
    end

    assign validOut  = gStage[LAST].stage_reg.valid & ~recover_i;
    assign payload_o = gStage[LAST].stage_reg.payload;
    assign phySrc_o  = gStage[LAST].stage_reg.tags;
    assign rfAddr_o  = gStage[LAST].stage_reg.tags;

    // Captured data first, then a live bypass hit, then the register file.
    for (genvar gk = 0; gk < NUM_SRC; gk++) begin : gOut
      assign srcData_o[gk*DATA_W +: DATA_W] =
        validOut ? (gStage[LAST].capNext[gk] ? gStage[LAST].dataNext[gk]
                                              : rfData_i[gk*DATA_W +: DATA_W]) : '0;
    end
  end

endmodule

// File: tb/tb_reg_read_pipe.sv
// Directed bench for reg_read_pipe (RR_DEPTH=3) with an instruction-level reference model.
module tb_reg_read_pipe;

  localparam int PW = 128, NSRC = 2, IW = 4, DW = 64, PL = 7;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                recover_i = 1'b0;
  logic                valid_i = 1'b0;
  logic                ready_i = 1'b1;
  logic [PW-1:0]       payload_i = '0;
  logic [NSRC*PL-1:0]  phySrc_i = '0;
  logic [IW-1:0]       bypassValid_i = '0;
  logic [IW*PL-1:0]    bypassTag_i = '0;
  logic [IW*DW-1:0]    bypassData_i = '0;
  logic [NSRC*DW-1:0]  rfData_i = {64'h22, 64'h11};
  logic                ready_o, valid_o;
  logic [NSRC*PL-1:0]  rfAddr_o, phySrc_o;
  logic [PW-1:0]       payload_o;
  logic [NSRC*DW-1:0]  srcData_o;

  int checks = 0;
  int errors = 0;

  // Model: slot 1 is the instruction presented at the output.
  bit            mValid [2];
  logic [PW-1:0] mPayload [2];
  logic [PL-1:0] mTag [2][NSRC];
  bit            mGot [2][NSRC];
  logic [DW-1:0] mVal [2][NSRC];

  reg_read_pipe #(
    .RR_DEPTH(3), .NUM_SRC(NSRC), .ISSUE_WIDTH(IW), .DATA_W(DW), .PHYS_LOG(PL), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .recover_i(recover_i), .valid_i(valid_i), .ready_o(ready_o),
    .payload_i(payload_i), .phySrc_i(phySrc_i), .bypassValid_i(bypassValid_i),
    .bypassTag_i(bypassTag_i), .bypassData_i(bypassData_i), .rfAddr_o(rfAddr_o),
    .rfData_i(rfData_i), .valid_o(valid_o), .ready_i(ready_i), .payload_o(payload_o),
    .phySrc_o(phySrc_o), .srcData_o(srcData_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit busLookup(input logic [PL-1:0] tag, output logic [DW-1:0] d);
    d = '0;
    for (int j = 0; j < IW; j++) begin
      if (bypassValid_i[j] && bypassTag_i[j*PL +: PL] == tag) begin
        d = bypassData_i[j*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin : cmp
    logic expValid, expReady, hit;
    logic [DW-1:0] d, expData;
    logic [NSRC*PL-1:0] expTags;
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        mValid[s] = 1'b0;
        for (int k = 0; k < NSRC; k++) mGot[s][k] = 1'b0;
      end
      chk("rst_valid_o", valid_o, 1'b0);
      chk("rst_ready_o", ready_o, 1'b1);
    end else begin
      expValid = mValid[1] && !recover_i;
      expReady = !(expValid && !ready_i);
      chk("valid_o", valid_o, expValid);
      chk("ready_o", ready_o, expReady);
      if (expValid) begin
        for (int k = 0; k < NSRC; k++) expTags[k*PL +: PL] = mTag[1][k];
        chk("payload_o", payload_o, mPayload[1]);
        chk("phySrc_o", phySrc_o, expTags);
        chk("rfAddr_o", rfAddr_o, expTags);
        for (int k = 0; k < NSRC; k++) begin
          hit = busLookup(mTag[1][k], d);
          if (mGot[1][k]) expData = mVal[1][k];
          else if (hit) expData = d;
          else expData = rfData_i[k*DW +: DW];
          chk($sformatf("srcData_o[%0d]", k), srcData_o[k*DW +: DW], expData);
        end
        if (ready_i)
          $display("OUT payload=%0h src0=%0h src1=%0h", payload_o, srcData_o[63:0], srcData_o[127:64]);
      end
      if (recover_i) begin
        for (int s = 0; s < 2; s++) begin
          mValid[s] = 1'b0;
          for (int k = 0; k < NSRC; k++) mGot[s][k] = 1'b0;
        end
      end else begin
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < NSRC; k++)
            if (mValid[s] && !mGot[s][k]) begin
              hit = busLookup(mTag[s][k], d);
              if (hit) begin
                mGot[s][k] = 1'b1;
                mVal[s][k] = d;
              end
            end
        if (expReady) begin
          mValid[1] = mValid[0];
          mPayload[1] = mPayload[0];
          for (int k = 0; k < NSRC; k++) begin
            mTag[1][k] = mTag[0][k];
            mGot[1][k] = mGot[0][k];
            mVal[1][k] = mVal[0][k];
            mTag[0][k] = phySrc_i[k*PL +: PL];
            mGot[0][k] = 1'b0;
          end
          mValid[0] = valid_i;
          mPayload[0] = payload_i;
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    recover_i = 1'b0;
    bypassValid_i = '0;
    bypassTag_i = '0;
    bypassData_i = '0;
  endtask

  task automatic inject(input logic [PW-1:0] p, input logic [PL-1:0] t0, input logic [PL-1:0] t1);
    valid_i = 1'b1;
    payload_i = p;
    phySrc_i = {t1, t0};
  endtask

  task automatic setBus(input int j, input logic [PL-1:0] t, input logic [DW-1:0] d, input logic v);
    bypassValid_i[j] = v;
    bypassTag_i[j*PL +: PL] = t;
    bypassData_i[j*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    @(negedge clk); @(negedge clk);
    chk("reset valid_o", valid_o, 1'b0);
    chk("reset ready_o", ready_o, 1'b1);
    chk("reset payload_o", payload_o, '0);
    chk("reset phySrc_o", phySrc_o, '0);
    chk("reset rfAddr_o", rfAddr_o, '0);
    chk("reset srcData_o", srcData_o, '0);
    @(posedge clk); #1 reset = 1'b1;

    // 1: plain flow, register-file operands
    nextCycle(); inject(128'hA1, 7'd5, 7'd9);
    nextCycle();
    nextCycle(); @(negedge clk);
    chk("t1 valid_o", valid_o, 1'b1);
    chk("t1 src0", srcData_o[63:0], 64'h11);
    chk("t1 src1", srcData_o[127:64], 64'h22);
    chk("t1 rfAddr_o", rfAddr_o, {7'd9, 7'd5});
    nextCycle(); @(negedge clk);
    chk("t1 drained", valid_o, 1'b0);

    // 2: bypass caught mid-pipe
    nextCycle(); inject(128'hA2, 7'd5, 7'd9);
    nextCycle(); setBus(2, 7'd5, 64'hAA, 1'b1);
    nextCycle(); @(negedge clk);
    chk("t2 src0", srcData_o[63:0], 64'hAA);
    chk("t2 src1", srcData_o[127:64], 64'h22);

    // 3: capture while stalled, offered instruction refused
    nextCycle(); inject(128'hA3, 7'd5, 7'd9);
    nextCycle();
    nextCycle(); ready_i = 1'b0; @(negedge clk);
    chk("t3 ready_o c2", ready_o, 1'b0);
    chk("t3 payload c2", payload_o, 128'hA3);
    nextCycle(); inject(128'hBAD, 7'd1, 7'd2); @(negedge clk);
    chk("t3 ready_o c3", ready_o, 1'b0);
    chk("t3 payload c3", payload_o, 128'hA3);
    nextCycle(); setBus(0, 7'd9, 64'hBB, 1'b1); @(negedge clk);
    chk("t3 ready_o c4", ready_o, 1'b0);
    nextCycle(); @(negedge clk);
    chk("t3 ready_o c5", ready_o, 1'b0);
    chk("t3 src1 held c5", srcData_o[127:64], 64'hBB);
    chk("t3 payload c5", payload_o, 128'hA3);
    nextCycle(); ready_i = 1'b1; @(negedge clk);
    chk("t3 valid_o c6", valid_o, 1'b1);
    chk("t3 ready_o c6", ready_o, 1'b1);
    chk("t3 src0 c6", srcData_o[63:0], 64'h11);
    chk("t3 src1 c6", srcData_o[127:64], 64'hBB);
    nextCycle(); @(negedge clk);
    chk("t3 no refused instr", valid_o, 1'b0);

    // 4: lowest bus wins, later broadcast ignored, invalid bus ignored
    nextCycle(); inject(128'hA4, 7'd5, 7'd9);
    nextCycle(); setBus(1, 7'd5, 64'h01, 1'b1); setBus(3, 7'd5, 64'h03, 1'b1);
    setBus(0, 7'd9, 64'hEE, 1'b0);
    nextCycle(); setBus(0, 7'd5, 64'h77, 1'b1); @(negedge clk);
    chk("t4 src0", srcData_o[63:0], 64'h01);
    chk("t4 src1", srcData_o[127:64], 64'h22);

    // Tag 0 is ordinary: live bypass beats register file at the output
    nextCycle(); inject(128'hA7, 7'd0, 7'd3);
    nextCycle();
    nextCycle(); setBus(2, 7'd0, 64'h55, 1'b1); setBus(1, 7'd3, 64'h66, 1'b0); @(negedge clk);
    chk("t7 src0", srcData_o[63:0], 64'h55);
    chk("t7 src1", srcData_o[127:64], 64'h22);
    chk("t7 rfAddr_o", rfAddr_o, {7'd3, 7'd0});

    // 5: recover during a stall
    nextCycle(); inject(128'hB1, 7'd1, 7'd2);
    nextCycle(); inject(128'hB2, 7'd3, 7'd4);
    nextCycle(); ready_i = 1'b0; inject(128'hB3, 7'd5, 7'd6); @(negedge clk);
    chk("t5 stall valid_o", valid_o, 1'b1);
    chk("t5 stall ready_o", ready_o, 1'b0);
    nextCycle(); recover_i = 1'b1; inject(128'hB3, 7'd5, 7'd6); @(negedge clk);
    chk("t5 recover valid_o", valid_o, 1'b0);
    chk("t5 recover ready_o", ready_o, 1'b1);
    nextCycle(); ready_i = 1'b1; inject(128'hB4, 7'd5, 7'd9); @(negedge clk);
    chk("t5 c4 valid_o", valid_o, 1'b0);
    nextCycle(); @(negedge clk);
    chk("t5 c5 valid_o", valid_o, 1'b0);
    nextCycle(); @(negedge clk);
    chk("t5 c6 valid_o", valid_o, 1'b1);
    chk("t5 c6 payload", payload_o, 128'hB4);
    nextCycle(); @(negedge clk);
    chk("t5 c7 valid_o", valid_o, 1'b0);

    // 6: asynchronous reset with a full, stalled pipe
    nextCycle(); inject(128'hC1, 7'd5, 7'd9);
    nextCycle(); inject(128'hC2, 7'd1, 7'd2);
    nextCycle(); ready_i = 1'b0; inject(128'hC3, 7'd3, 7'd4);
    #2 reset = 1'b0;
    #1;
    chk("t6 async valid_o", valid_o, 1'b0);
    chk("t6 async ready_o", ready_o, 1'b1);
    chk("t6 async payload_o", payload_o, '0);
    chk("t6 async rfAddr_o", rfAddr_o, '0);
    chk("t6 async srcData_o", srcData_o, '0);
    nextCycle(); reset = 1'b1; ready_i = 1'b1;
    nextCycle(); inject(128'hC4, 7'd6, 7'd7);
    nextCycle();
    nextCycle(); @(negedge clk);
    chk("t6 after reset valid_o", valid_o, 1'b1);
    chk("t6 after reset payload", payload_o, 128'hC4);
    nextCycle(); nextCycle(); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
